// File: rtl/wb_mem_bist.sv
// Wishbone memory self-test initiator: writes seed-minus-address pattern over a
// word range, reads it back, reports first mismatch or bus timeout.
module wb_mem_bist #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRIDE  = 4,
    parameter int unsigned TMO_CYC = 15
) (
    input  logic                wb_clk,
    input  logic                wb_reset,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   addr_lo_i,
    input  logic [ADDR_W-1:0]   addr_hi_i,
    input  logic [DATA_W-1:0]   seed_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic [DATA_W-1:0]   err_data_o,
    output logic [DATA_W-1:0]   err_exp_o,
    output logic                m_wb_cyc_o,
    output logic                m_wb_stb_o,
    output logic                m_wb_we_o,
    output logic [ADDR_W-1:0]   m_wb_addr_o,
    output logic [DATA_W-1:0]   m_wb_data_o,
    output logic [DATA_W/8-1:0] m_wb_sel_o,
    input  logic                m_wb_stall_i,
    input  logic                m_wb_ack_i,
    input  logic [DATA_W-1:0]   m_wb_data_i
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   seed_q;
    logic [ADDR_W-1:0]   lo_q;
    logic [ADDR_W-1:0]   hi_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                timeout_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [DATA_W-1:0]   err_data_q;
    logic [DATA_W-1:0]   err_exp_q;
    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_data_q;

    logic [ADDR_W-1:0]   lo_al;
    logic [ADDR_W-1:0]   hi_al;
    logic [DATA_W-1:0]   exp_data;
    logic [ADDR_W:0]     addr_nxt;
    logic                is_last;
    logic                in_req;
    logic                in_wr;
    logic                accept;
    logic                ack_ok;
    logic                tmo_hit;

    // Word-aligned range, expected pattern, and per-cycle handshake decode
    assign lo_al    = addr_lo_i & ~ADDR_W'(3);
    assign hi_al    = addr_hi_i & ~ADDR_W'(3);
    assign exp_data = seed_q - DATA_W'(addr_q);
    assign addr_nxt = {1'b0, addr_q} + (ADDR_W + 1)'(STRIDE);
    assign is_last  = addr_nxt > {1'b0, hi_q};
    assign in_req   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign in_wr    = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign accept   = stb_q && !m_wb_stall_i;
    // An ack counts only inside a live cycle: in REQ it must coincide with acceptance
    assign ack_ok   = cyc_q && m_wb_ack_i && (in_req ? accept : 1'b1);
    assign tmo_hit  = tmo_q == TMO_W'(TMO_CYC - 1);

    // Test sequencer; REQ entered with cyc low first issues the request, which
    // guarantees an idle bus cycle between back-to-back transactions
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
            err_exp_q  <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        seed_q     <= seed_i;
                        lo_q       <= lo_al;
                        hi_q       <= hi_al;
                        timeout_q  <= 1'b0;
                        err_addr_q <= '0;
                        err_data_q <= '0;
                        err_exp_q  <= '0;
                        if (lo_al <= hi_al) begin
                            addr_q  <= lo_al;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            state_q <= WR_REQ;
                        end else begin
                            pass_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                WR_REQ, WR_WAIT, RD_REQ, RD_WAIT: begin
                    if (in_req && !cyc_q) begin
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        we_q       <= in_wr;
                        bus_addr_q <= addr_q;
                        bus_data_q <= in_wr ? exp_data : '0;
                        tmo_q      <= '0;
                    end else if (ack_ok) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (!in_wr && (m_wb_data_i != exp_data)) begin
                            err_addr_q <= addr_q;
                            err_data_q <= m_wb_data_i;
                            err_exp_q  <= exp_data;
                            pass_q     <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= FINISH;
                        end else if (is_last) begin
                            if (in_wr) begin
                                addr_q  <= lo_q;
                                state_q <= RD_REQ;
                            end else begin
                                pass_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= FINISH;
                            end
                        end else begin
                            addr_q  <= addr_nxt[ADDR_W-1:0];
                            state_q <= in_wr ? WR_REQ : RD_REQ;
                        end
                    end else if (tmo_hit) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        timeout_q  <= 1'b1;
                        pass_q     <= 1'b0;
                        err_addr_q <= addr_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FINISH;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        if (in_req && accept) begin
                            stb_q   <= 1'b0;
                            state_q <= in_wr ? WR_WAIT : RD_WAIT;
                        end
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign err_addr_o  = err_addr_q;
    assign err_data_o  = err_data_q;
    assign err_exp_o   = err_exp_q;
    assign m_wb_cyc_o  = cyc_q;
    assign m_wb_stb_o  = stb_q;
    assign m_wb_we_o   = we_q;
    assign m_wb_addr_o = bus_addr_q;
    assign m_wb_data_o = bus_data_q;
    assign m_wb_sel_o  = '1;

endmodule

// File: tb/tb_wb_mem_bist.sv
// Bench for wb_mem_bist: behavioural RAM responder plus transaction scoreboard.
module tb_wb_mem_bist;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;

    logic              wb_clk = 1'b0;
    logic              wb_reset;
    logic              start_i;
    logic [ADDR_W-1:0] addr_lo_i, addr_hi_i;
    logic [DATA_W-1:0] seed_i;
    logic              busy_o, done_o, pass_o, timeout_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic [DATA_W-1:0] err_data_o, err_exp_o;
    logic              m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
    logic [ADDR_W-1:0] m_wb_addr_o;
    logic [DATA_W-1:0] m_wb_data_o;
    logic [3:0]        m_wb_sel_o;
    logic              m_wb_stall_i, m_wb_ack_i;
    logic [DATA_W-1:0] m_wb_data_i;

    wb_mem_bist dut (
        .wb_clk(wb_clk), .wb_reset(wb_reset), .start_i(start_i),
        .addr_lo_i(addr_lo_i), .addr_hi_i(addr_hi_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_addr_o(err_addr_o), .err_data_o(err_data_o), .err_exp_o(err_exp_o),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_addr_o(m_wb_addr_o), .m_wb_data_o(m_wb_data_o), .m_wb_sel_o(m_wb_sel_o),
        .m_wb_stall_i(m_wb_stall_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_data_i(m_wb_data_i)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    txn_t              exp_q[$];
    logic [DATA_W-1:0] mem [512];

    int n_cmp = 0;
    int n_err = 0;

    int          stall_n = 0;
    bit          zero_lat = 0, noack_en = 0, corrupt_en = 0, spur_ack = 0;
    logic [10:0] noack_addr = '0, corrupt_addr = '0;
    int          ntx = 0, cyc_cycles = 0, run = 0, last_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic complete_txn(input txn_t t);
        if (noack_en && t.we && t.addr == noack_addr) return;
        if (t.we) mem[t.addr[10:2]] = t.data;
        else begin
            m_wb_data_i = mem[t.addr[10:2]];
            if (corrupt_en && t.addr == corrupt_addr) m_wb_data_i = m_wb_data_i ^ 32'h1;
        end
        m_wb_ack_i = 1'b1;
    endtask

    task automatic score(input txn_t cur);
        txn_t e;
        chk("q_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("txn_we", 64'(cur.we), 64'(e.we));
            chk("txn_addr", 64'(cur.addr), 64'(e.addr));
            if (e.we) chk("txn_wdata", 64'(cur.data), 64'(e.data));
        end
    endtask

    // RAM responder: drives stall/ack/data on the falling edge for the next rising edge
    task automatic responder();
        txn_t pend, cur, first;
        bit   pend_v = 0, seen = 0;
        int   scnt = 0;
        forever begin
            @(negedge wb_clk);
            m_wb_ack_i = 1'b0;
            if (wb_reset) begin
                pend_v = 0; seen = 0; scnt = 0; run = 0;
                m_wb_stall_i = 1'b0;
                continue;
            end
            if (m_wb_cyc_o) begin
                run++; cyc_cycles++;
            end else if (run > 0) begin
                last_run = run; run = 0;
            end
            if (m_wb_stb_o) chk("stb_implies_cyc", 64'(m_wb_cyc_o), 64'(1));
            if (pend_v) begin
                pend_v = 0;
                complete_txn(pend);
            end
            if (m_wb_cyc_o && m_wb_stb_o) begin
                cur = {m_wb_we_o, m_wb_addr_o, m_wb_data_o};
                if (seen) chk("stb_hold", 64'(cur), 64'(first));
                else begin seen = 1; first = cur; end
                if (scnt < stall_n) begin
                    m_wb_stall_i = 1'b1; scnt++;
                end else begin
                    m_wb_stall_i = 1'b0; scnt = 0; seen = 0; ntx++;
                    score(cur);
                    if (zero_lat) complete_txn(cur);
                    else begin pend = cur; pend_v = 1; end
                end
            end else begin
                m_wb_stall_i = 1'b0;
            end
            if (spur_ack) m_wb_ack_i = 1'b1;
        end
    endtask

    task automatic push_range(input int lo, input int last, input logic [31:0] seed, input logic we);
        txn_t t;
        for (int a = lo; a <= last; a += 4) begin
            t.we = we; t.addr = 11'(a); t.data = seed - 32'(a);
            exp_q.push_back(t);
        end
    endtask

    task automatic run_test(input logic [10:0] lo, input logic [10:0] hi, input logic [31:0] seed,
                            input int poke, input bit exp_busy, output int n);
        @(negedge wb_clk);
        addr_lo_i = lo; addr_hi_i = hi; seed_i = seed; start_i = 1'b1;
        n = 0;
        do begin
            @(negedge wb_clk);
            n++;
            start_i = (poke > 0 && n == poke);
            if (start_i) begin seed_i = ~seed; addr_lo_i = '0; addr_hi_i = '0; end
            if (n == 1) chk("busy_start", 64'(busy_o), 64'(exp_busy));
        end while (!done_o && n < 20000);
        start_i = 1'b0;
        chk("done_seen", 64'(done_o), 64'(1));
        chk("busy_at_done", 64'(busy_o), 64'(0));
        @(negedge wb_clk);
        chk("done_pulse", 64'(done_o), 64'(0));
    endtask

    initial begin
        int n, n0, c0;
        bit found;
        logic [31:0] seed;
        wb_reset = 1'b1; start_i = 1'b0; addr_lo_i = '0; addr_hi_i = '0; seed_i = '0;
        m_wb_stall_i = 1'b0; m_wb_ack_i = 1'b0; m_wb_data_i = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        fork responder(); join_none
        repeat (2) @(negedge wb_clk);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_pass", 64'(pass_o), 64'(0));
        chk("rst_cyc", 64'(m_wb_cyc_o), 64'(0));
        chk("rst_stb", 64'(m_wb_stb_o), 64'(0));
        chk("rst_err_addr", 64'(err_addr_o), 64'(0));
        wb_reset = 1'b0;

        // ack while idle is ignored
        spur_ack = 1; repeat (2) @(negedge wb_clk); spur_ack = 0;
        @(negedge wb_clk);
        chk("spur_busy", 64'(busy_o), 64'(0));
        chk("spur_cyc", 64'(m_wb_cyc_o), 64'(0));

        // full range, 1-cycle ack
        push_range(0, 32'h7FC, 32'hFFFF_FFFF, 1'b1);
        push_range(0, 32'h7FC, 32'hFFFF_FFFF, 1'b0);
        n0 = ntx;
        run_test(11'h000, 11'h7FC, 32'hFFFF_FFFF, 0, 1'b1, n);
        chk("t1_pass", 64'(pass_o), 64'(1));
        chk("t1_tmo", 64'(timeout_o), 64'(0));
        chk("t1_ntx", 64'(ntx - n0), 64'(1024));
        chk("t1_q_empty", 64'(exp_q.size()), 64'(0));
        chk("t1_mem_020", 64'(mem[8]), 64'(32'hFFFF_FFDF));
        chk("t1_sel", 64'(m_wb_sel_o), 64'(4'hF));

        // stall 3 cycles on every request
        stall_n = 3; seed = $urandom;
        push_range(0, 32'h7FC, seed, 1'b1);
        push_range(0, 32'h7FC, seed, 1'b0);
        n0 = ntx;
        run_test(11'h000, 11'h7FF, seed, 0, 1'b1, n);
        chk("t2_pass", 64'(pass_o), 64'(1));
        chk("t2_ntx", 64'(ntx - n0), 64'(1024));
        chk("t2_q_empty", 64'(exp_q.size()), 64'(0));
        stall_n = 0;

        // ack in the accept cycle
        zero_lat = 1; seed = $urandom;
        push_range(32'h100, 32'h1FC, seed, 1'b1);
        push_range(32'h100, 32'h1FC, seed, 1'b0);
        run_test(11'h101, 11'h1FE, seed, 0, 1'b1, n);
        chk("t2b_pass", 64'(pass_o), 64'(1));
        chk("t2b_q_empty", 64'(exp_q.size()), 64'(0));
        zero_lat = 0;

        // corrupted read at 0x104
        corrupt_en = 1; corrupt_addr = 11'h104; seed = 32'h1234_5678;
        push_range(0, 32'h7FC, seed, 1'b1);
        push_range(0, 32'h104, seed, 1'b0);
        run_test(11'h000, 11'h7FC, seed, 0, 1'b1, n);
        chk("t3_pass", 64'(pass_o), 64'(0));
        chk("t3_err_addr", 64'(err_addr_o), 64'(11'h104));
        chk("t3_err_exp", 64'(err_exp_o), 64'(seed - 32'h104));
        chk("t3_err_data", 64'(err_data_o), 64'((seed - 32'h104) ^ 32'h1));
        chk("t3_tmo", 64'(timeout_o), 64'(0));
        chk("t3_q_empty", 64'(exp_q.size()), 64'(0));
        corrupt_en = 0;

        // write at 0x008 never acked
        noack_en = 1; noack_addr = 11'h008; seed = $urandom;
        push_range(0, 32'h008, seed, 1'b1);
        run_test(11'h000, 11'h7FC, seed, 0, 1'b1, n);
        chk("t4_tmo", 64'(timeout_o), 64'(1));
        chk("t4_pass", 64'(pass_o), 64'(0));
        chk("t4_err_addr", 64'(err_addr_o), 64'(11'h008));
        chk("t4_cyc_len", 64'(last_run), 64'(15));
        chk("t4_q_empty", 64'(exp_q.size()), 64'(0));
        noack_en = 0;

        // empty range: lo > hi
        c0 = cyc_cycles;
        run_test(11'h010, 11'h00C, 32'hA5A5_A5A5, 0, 1'b0, n);
        chk("t5_done_lat", 64'(n), 64'(1));
        chk("t5_pass", 64'(pass_o), 64'(1));
        chk("t5_tmo_clr", 64'(timeout_o), 64'(0));
        chk("t5_err_clr", 64'(err_addr_o), 64'(0));
        chk("t5_no_cyc", 64'(cyc_cycles - c0), 64'(0));

        // start pulsed while busy is ignored
        seed = $urandom;
        push_range(32'h40, 32'h13C, seed, 1'b1);
        push_range(32'h40, 32'h13C, seed, 1'b0);
        run_test(11'h040, 11'h13F, seed, 50, 1'b1, n);
        chk("t5b_pass", 64'(pass_o), 64'(1));
        chk("t5b_q_empty", 64'(exp_q.size()), 64'(0));

        // reset during RD_WAIT, then full rerun
        seed = $urandom;
        push_range(0, 32'h7FC, seed, 1'b1);
        push_range(0, 32'h7FC, seed, 1'b0);
        @(negedge wb_clk);
        addr_lo_i = 11'h000; addr_hi_i = 11'h7FC; seed_i = seed; start_i = 1'b1;
        @(negedge wb_clk);
        start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge wb_clk);
            found = (ntx - n0 >= 600) && m_wb_cyc_o && !m_wb_stb_o && !m_wb_we_o;
        end
        chk("t6_rd_wait_seen", 64'(found), 64'(1));
        #1 wb_reset = 1'b1;
        #1;
        chk("t6_rst_cyc", 64'(m_wb_cyc_o), 64'(0));
        chk("t6_rst_stb", 64'(m_wb_stb_o), 64'(0));
        chk("t6_rst_busy", 64'(busy_o), 64'(0));
        chk("t6_rst_pass", 64'(pass_o), 64'(0));
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_reset = 1'b0;
        exp_q.delete();
        seed = $urandom;
        push_range(0, 32'h7FC, seed, 1'b1);
        push_range(0, 32'h7FC, seed, 1'b0);
        n0 = ntx;
        run_test(11'h000, 11'h7FC, seed, 0, 1'b1, n);
        chk("t6_pass", 64'(pass_o), 64'(1));
        chk("t6_ntx", 64'(ntx - n0), 64'(1024));
        chk("t6_q_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
